msg_fifo: RTL and testbench



---
 rtl/msg_fifo_pkg.sv | 16 +
 rtl/msg_fifo_bram.sv | 29 ++
 rtl/msg_fifo.sv | 138 +++++++++++++
 tb/tb_msg_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_fifo_pkg.sv
// Shared GF(8) definitions for the message pipelines (check-node <-> variable-node).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: word/address widths and the symbol-pair view of a 6-bit message word.
package msg_fifo_pkg;

    localparam int GF8_DW = 6;   // message word width
    localparam int GF8_AW = 3;   // message store address width (depth 8)

    // A message word carries two GF(8) symbols; the FIFO moves them opaquely.
    typedef struct packed {
        logic [2:0] sym_hi;      // bits [5:3]
        logic [2:0] sym_lo;      // bits [2:0]
    } gf8_pair_t;

endpackage

// File: rtl/msg_fifo_bram.sv
// Simple dual-port RAM, 2**AW x DW, one write port, one registered-address read port.
// Latency: Dout = mem[Raddr sampled at the previous edge]; writes land at the edge.
// Backpressure: none, accepts a write and a read address every cycle.
// Ports: Clk; We/Waddr/Din write side; Raddr/Dout read side. Contents are never reset.
module bram #(
    parameter int DW = 6,
    parameter int AW = 3
) (
    input  logic          Clk,
    input  logic          We,
    input  logic [AW-1:0] Waddr,
    input  logic [DW-1:0] Din,
    input  logic [AW-1:0] Raddr,
    output logic [DW-1:0] Dout
);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] raddr_q;

    always_ff @(posedge Clk) begin
        if (We) begin
            mem_q[Waddr] <= Din;
        end
        raddr_q <= Raddr;
    end

    assign Dout = mem_q[raddr_q];

endmodule

// File: rtl/msg_fifo.sv
// Stream FIFO for GF(8) message words: bram store plus a two-entry output skid.
// Latency: a word pushed into an empty FIFO is presented two edges later; 1 word/clk sustained.
// Backpressure: In_ready = store not full; Out_valid/Out_data hold until Out_ready.
// Ports: Clk, Rst_n (async, active low); In_valid/In_ready/In_data producer side;
//        Out_valid/Out_ready/Out_data consumer side; Count = words held (0..10).
module msg_fifo
    import msg_fifo_pkg::*;
#(
    parameter int DW = GF8_DW,
    parameter int AW = GF8_AW
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          In_valid,
    output logic          In_ready,
    input  logic [DW-1:0] In_data,
    output logic          Out_valid,
    input  logic          Out_ready,
    output logic [DW-1:0] Out_data,
    output logic [3:0]    Count
);

    localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [AW:0]   mem_cnt, mem_cnt_d;
    logic          inflight_q, inflight_d;
    logic          out_v_q, out_v_d;
    logic          skid_v_q, skid_v_d;
    logic [DW-1:0] out_dat_q, out_dat_d;
    logic [DW-1:0] skid_dat_q, skid_dat_d;
    logic [3:0]    count_q, count_d;
    logic          rdy_en_q, rdy_en_d;
    logic [DW-1:0] dout;
    logic          full, empty, push, pop, fetch;
    logic [1:0]    occ;

    assign mem_cnt = wptr_q - rptr_q;
    assign full    = (mem_cnt == DEPTH_V);
    assign empty   = (mem_cnt == '0);

    // rdy_en_q keeps In_ready low during reset and lifts it on the first edge after release.
    assign In_ready = rdy_en_q & ~full;
    assign push     = In_valid & In_ready;
    assign pop      = out_v_q & Out_ready;

    // Words already committed to the output side (in flight, output reg, skid).
    // Fetch only while the output side would still hold fewer than two after this pop,
    // so a returning word always has a register to land in.
    assign occ   = {1'b0, inflight_q} + {1'b0, out_v_q} + {1'b0, skid_v_q};
    assign fetch = ~empty & ((occ - {1'b0, pop}) < 2'd2);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        inflight_d = fetch;
        out_v_d    = out_v_q;
        out_dat_d  = out_dat_q;
        skid_v_d   = skid_v_q;
        skid_dat_d = skid_dat_q;
        rdy_en_d   = 1'b1;

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (fetch) begin
            rptr_d = rptr_q + 1'b1;
        end

        // The skid is always older than the returning word, so it drains first.
        if (pop) begin
            if (skid_v_q) begin
                out_dat_d = skid_dat_q;
                skid_v_d  = inflight_q;
                if (inflight_q) begin
                    skid_dat_d = dout;
                end
            end else if (inflight_q) begin
                out_dat_d = dout;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (inflight_q) begin
            if (!out_v_q) begin
                out_v_d   = 1'b1;
                out_dat_d = dout;
            end else begin
                skid_v_d   = 1'b1;
                skid_dat_d = dout;
            end
        end

        mem_cnt_d = wptr_d - rptr_d;
        count_d   = 4'(mem_cnt_d) + {3'b0, inflight_d} + {3'b0, out_v_d} + {3'b0, skid_v_d};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            out_v_q    <= 1'b0;
            out_dat_q  <= '0;
            skid_v_q   <= 1'b0;
            skid_dat_q <= '0;
            count_q    <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            out_v_q    <= out_v_d;
            out_dat_q  <= out_dat_d;
            skid_v_q   <= skid_v_d;
            skid_dat_q <= skid_dat_d;
            count_q    <= count_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    bram #(
        .DW(DW),
        .AW(AW)
    ) u_bram (
        .Clk   (Clk),
        .We    (push),
        .Waddr (wptr_q[AW-1:0]),
        .Din   (In_data),
        .Raddr (rptr_q[AW-1:0]),
        .Dout  (dout)
    );

    assign Out_valid = out_v_q;
    assign Out_data  = out_dat_q;
    assign Count     = count_q;

endmodule

// File: tb/tb_msg_fifo.sv
// Testbench for msg_fifo: directed vectors plus a queue model of FIFO contents.
// Latency: n/a.
// Backpressure: exercised via Out_ready patterns.
module tb_msg_fifo;

    logic       Clk;
    logic       Rst_n;
    logic       In_valid;
    logic       In_ready;
    logic [5:0] In_data;
    logic       Out_valid;
    logic       Out_ready;
    logic [5:0] Out_data;
    logic [3:0] Count;

    int total = 0;
    int bad   = 0;
    int n_push = 0;
    int n_pop  = 0;

    logic [5:0] model_q[$];
    logic       prev_stall;
    logic [5:0] prev_data;

    msg_fifo dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .In_data   (In_data),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out_data  (Out_data),
        .Count     (Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Model: the FIFO is an ordered queue of accepted words. Count equals the
    // queue length, every popped word must equal the queue head, and a stalled
    // head must not change.
    always @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            model_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("count", int'(Count), model_q.size());
            if (model_q.size() < 8) begin
                chk("in_ready_open", int'(In_ready), 1);
            end else if (model_q.size() == 10) begin
                chk("in_ready_full", int'(In_ready), 0);
            end
            if (prev_stall) begin
                chk("stall_valid", int'(Out_valid), 1);
                chk("stall_data", int'(Out_data), int'(prev_data));
            end
            if (Out_valid && Out_ready) begin
                if (model_q.size() > 0) begin
                    chk("out_data", int'(Out_data), int'(model_q.pop_front()));
                end else begin
                    total++;
                    bad++;
                    $display("FAIL pop_empty: got word %0d expected no word", Out_data);
                end
                n_pop++;
            end
            if (In_valid && In_ready) begin
                model_q.push_back(In_data);
                n_push++;
            end
            prev_stall = Out_valid && !Out_ready;
            prev_data  = Out_data;
        end
    end

    initial begin
        logic ok;
        int acc, acc3, acc4, first, gaps, w;

        Rst_n     = 1'b1;
        In_valid  = 1'b0;
        In_data   = '0;
        Out_ready = 1'b0;
        #1 Rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(Out_valid), 0);
        chk("rst_out_data", int'(Out_data), 0);
        chk("rst_count", int'(Count), 0);
        chk("rst_in_ready", int'(In_ready), 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        step();
        chk("rdy_after_release", int'(In_ready), 1);

        // Single push of 0x2A into an empty FIFO.
        In_valid = 1'b1;
        In_data  = 6'h2A;
        step();                                   // edge N
        In_valid = 1'b0;
        step();                                   // edge N+1
        chk("t1_count_n1", int'(Count), 1);
        chk("t1_valid_n1", int'(Out_valid), 0);
        step();                                   // edge N+2
        chk("t1_valid_n2", int'(Out_valid), 1);
        chk("t1_data_n2", int'(Out_data), 'h2A);
        chk("t1_count_n2", int'(Count), 1);

        // Push and pop in the same cycle with Count=1.
        Out_ready = 1'b1;
        In_valid  = 1'b1;
        In_data   = 6'h33;
        step();                                   // edge M
        In_valid  = 1'b0;
        Out_ready = 1'b0;
        chk("t6_count_m", int'(Count), 1);
        chk("t6_valid_m", int'(Out_valid), 0);
        step();
        chk("t6_count_m1", int'(Count), 1);
        step();
        chk("t6_valid_m2", int'(Out_valid), 1);
        chk("t6_data_m2", int'(Out_data), 'h33);
        Out_ready = 1'b1;
        step();
        Out_ready = 1'b0;
        chk("t6_count_end", int'(Count), 0);
        chk("t6_valid_end", int'(Out_valid), 0);

        // Fill with the consumer stalled: 8 in bram + output + skid.
        acc = 0;
        In_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            In_data = 6'(acc);
            #2;
            ok = In_ready;
            step();
            if (ok) acc++;
        end
        In_valid = 1'b0;
        chk("t2_accepted", acc, 10);
        chk("t2_count", int'(Count), 10);
        chk("t2_in_ready", int'(In_ready), 0);
        Out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #2;
            chk("t2_drain_valid", int'(Out_valid), 1);
            chk("t2_drain_data", int'(Out_data), j);
            step();
        end
        Out_ready = 1'b0;
        chk("t2_count_empty", int'(Count), 0);

        // Full-rate streaming.
        acc3  = 0;
        first = -1;
        gaps  = 0;
        In_valid  = 1'b1;
        Out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            In_data = 6'(c * 5 + 1);
            #2;
            if (In_ready) acc3++;
            if (Out_valid) begin
                if (first < 0) first = c;
            end else if (first >= 0) begin
                gaps++;
            end
            step();
        end
        In_valid = 1'b0;
        chk("t3_accepted", acc3, 40);
        chk("t3_first_out", first, 3);
        chk("t3_gaps", gaps, 0);
        for (int c = 0; c < 10 && Count != 0; c++) step();
        chk("t3_drained", int'(Count), 0);
        Out_ready = 1'b0;

        // Random traffic and backpressure.
        acc4 = 0;
        for (int c = 0; c < 5000 && acc4 < 500; c++) begin
            In_valid  = ($urandom_range(0, 3) != 0);
            Out_ready = $urandom_range(0, 1) == 1;
            In_data   = 6'($urandom);
            #2;
            if (In_valid && In_ready) acc4++;
            step();
        end
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        chk("t4_pushed", acc4, 500);
        for (int c = 0; c < 20 && Count != 0; c++) step();
        chk("t4_drained", int'(Count), 0);
        chk("t4_model_empty", model_q.size(), 0);
        chk("t4_balance", n_pop, n_push);
        Out_ready = 1'b0;

        // Async reset with output and skid occupied.
        In_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            In_data = 6'(k + 40);
            step();
        end
        In_valid = 1'b0;
        step();
        step();
        chk("t5_count_pre", int'(Count), 7);
        chk("t5_valid_pre", int'(Out_valid), 1);
        #2 Rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", int'(Out_valid), 0);
        chk("t5_rst_count", int'(Count), 0);
        chk("t5_rst_in_ready", int'(In_ready), 0);
        chk("t5_rst_data", int'(Out_data), 0);
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        step();
        step();
        chk("t5_no_spurious", int'(Out_valid), 0);
        chk("t5_count_after", int'(Count), 0);
        In_valid = 1'b1;
        In_data  = 6'h15;
        step();
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        w = 0;
        while (!Out_valid && w < 10) begin
            step();
            w++;
        end
        chk("t5_first_valid", int'(Out_valid), 1);
        chk("t5_first_word", int'(Out_data), 'h15);
        step();
        step();
        Out_ready = 1'b0;
        chk("t5_final_count", int'(Count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
